// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for the set-associative cache datapath: probe, dirty-victim
// writeback, refill and replay, with saturating hit/miss/writeback counters.
module cache_ctrl_fsm #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 64,
    parameter int NUM_WAYS        = 4,
    parameter int CNT_WIDTH       = 32,
    localparam int OFFSET_WIDTH   = $clog2(WORDS_PER_BLOCK),
    localparam int NUM_SETS       = NUM_BLOCKS / NUM_WAYS,
    localparam int INDEX_WIDTH    = $clog2(NUM_SETS),
    localparam int TAG_WIDTH      = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req_valid,
    input  logic                    cpu_req_type,
    input  logic [31:0]             cpu_addr,
    output logic                    cpu_ready,
    output logic                    cpu_resp_valid,
    output logic [TAG_WIDTH-1:0]    tag,
    output logic [INDEX_WIDTH-1:0]  index,
    output logic [OFFSET_WIDTH-1:0] blk_offset,
    output logic                    req_type,
    output logic                    read_en_cache,
    output logic                    write_en_cache,
    output logic                    read_en_mem,
    output logic                    write_en_mem,
    input  logic                    hit,
    input  logic                    dirty_bit,
    output logic                    mem_req,
    output logic                    mem_rw,
    input  logic                    mem_ready,
    output logic [CNT_WIDTH-1:0]    hit_cnt,
    output logic [CNT_WIDTH-1:0]    miss_cnt,
    output logic [CNT_WIDTH-1:0]    wb_cnt
);

    if (WORD_SIZE <= 0 || TAG_WIDTH <= 0) begin : g_bad_cfg
        $error("cache_ctrl_fsm: invalid geometry");
    end

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PROBE      = 3'd1,
        S_CHECK      = 3'd2,
        S_WRITEBACK  = 3'd3,
        S_REFILL_REQ = 3'd4,
        S_REFILL     = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [31:0]            addr_r, addr_nxt_s;
    logic                   type_r, type_nxt_s;
    logic                   replay_r, replay_nxt_s;
    logic                   err_r, err_nxt_s;
    logic                   inc_hit_s, inc_miss_s, inc_wb_s;
    logic                   cpu_ready_r, cpu_resp_valid_r;
    logic                   read_en_cache_r, write_en_cache_r, read_en_mem_r, write_en_mem_r;
    logic                   mem_req_r, mem_rw_r;
    logic [CNT_WIDTH-1:0]   hit_cnt_r, miss_cnt_r, wb_cnt_r;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val,
                                                     input logic en);
        if (en && (val != {CNT_WIDTH{1'b1}})) begin
            return val + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return val;
        end
    endfunction

    // Next-state, request latch and counter-increment decode
    always_comb begin
        state_nxt_s  = state_r;
        addr_nxt_s   = addr_r;
        type_nxt_s   = type_r;
        replay_nxt_s = replay_r;
        err_nxt_s    = err_r;
        inc_hit_s    = 1'b0;
        inc_miss_s   = 1'b0;
        inc_wb_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    addr_nxt_s  = cpu_addr;
                    type_nxt_s  = cpu_req_type;
                    state_nxt_s = S_PROBE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_PROBE: state_nxt_s = S_CHECK;
            S_CHECK: begin
                if (hit) begin
                    inc_hit_s   = ~replay_r;
                    state_nxt_s = S_DONE;
                end else if (replay_r) begin
                    // a refill that still misses is a datapath fault, not a new miss
                    err_nxt_s   = 1'b1;
                    state_nxt_s = S_DONE;
                end else begin
                    inc_miss_s  = 1'b1;
                    state_nxt_s = dirty_bit ? S_WRITEBACK : S_REFILL_REQ;
                end
            end
            S_WRITEBACK: begin
                if (mem_ready) begin
                    inc_wb_s    = 1'b1;
                    state_nxt_s = S_REFILL_REQ;
                end else begin
                    state_nxt_s = S_WRITEBACK;
                end
            end
            S_REFILL_REQ: begin
                if (mem_ready) begin
                    state_nxt_s = S_REFILL;
                end else begin
                    state_nxt_s = S_REFILL_REQ;
                end
            end
            S_REFILL: begin
                replay_nxt_s = 1'b1;
                state_nxt_s  = S_PROBE;
            end
            S_DONE: begin
                replay_nxt_s = 1'b0;
                state_nxt_s  = S_IDLE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, latched request and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            addr_r     <= 32'd0;
            type_r     <= 1'b0;
            replay_r   <= 1'b0;
            err_r      <= 1'b0;
            hit_cnt_r  <= {CNT_WIDTH{1'b0}};
            miss_cnt_r <= {CNT_WIDTH{1'b0}};
            wb_cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            type_r     <= type_nxt_s;
            replay_r   <= replay_nxt_s;
            err_r      <= err_nxt_s;
            hit_cnt_r  <= sat_inc(hit_cnt_r, inc_hit_s);
            miss_cnt_r <= sat_inc(miss_cnt_r, inc_miss_s);
            wb_cnt_r   <= sat_inc(wb_cnt_r, inc_wb_s);
        end
    end

    // Control outputs registered from the next state so they align with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ready_r      <= 1'b1;
            cpu_resp_valid_r <= 1'b0;
            read_en_cache_r  <= 1'b0;
            write_en_cache_r <= 1'b0;
            read_en_mem_r    <= 1'b0;
            write_en_mem_r   <= 1'b0;
            mem_req_r        <= 1'b0;
            mem_rw_r         <= 1'b0;
        end else begin
            cpu_ready_r      <= (state_nxt_s == S_IDLE);
            cpu_resp_valid_r <= (state_nxt_s == S_DONE);
            read_en_cache_r  <= (state_nxt_s == S_PROBE) && !type_nxt_s;
            write_en_cache_r <= (state_nxt_s == S_PROBE) && type_nxt_s;
            read_en_mem_r    <= (state_nxt_s == S_REFILL);
            write_en_mem_r   <= (state_nxt_s == S_WRITEBACK);
            mem_req_r        <= (state_nxt_s == S_WRITEBACK) || (state_nxt_s == S_REFILL_REQ);
            mem_rw_r         <= (state_nxt_s == S_WRITEBACK);
        end
    end

    assign cpu_ready      = cpu_ready_r;
    assign cpu_resp_valid = cpu_resp_valid_r;
    assign tag            = addr_r[31:OFFSET_WIDTH+INDEX_WIDTH];
    assign index          = addr_r[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
    assign blk_offset     = addr_r[OFFSET_WIDTH-1:0];
    assign req_type       = type_r;
    assign read_en_cache  = read_en_cache_r;
    assign write_en_cache = write_en_cache_r;
    assign read_en_mem    = read_en_mem_r;
    assign write_en_mem   = write_en_mem_r;
    assign mem_req        = mem_req_r;
    assign mem_rw         = mem_rw_r;
    assign hit_cnt        = hit_cnt_r;
    assign miss_cnt       = miss_cnt_r;
    assign wb_cnt         = wb_cnt_r;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm: acts as cache_memory and main memory, checks
// latency, enable sequences, latched address, counters, reset abort and saturation.
module tb_cache_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid, cpu_req_type;
    logic [31:0] cpu_addr;
    logic        cpu_ready, cpu_resp_valid;
    logic [25:0] tag;
    logic [3:0]  index;
    logic [1:0]  blk_offset;
    logic        req_type;
    logic        read_en_cache, write_en_cache, read_en_mem, write_en_mem;
    logic        hit, dirty_bit, mem_req, mem_rw, mem_ready;
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;

    int vecs = 0;
    int miscompares = 0;
    int lat, n_rc, n_wc, n_rm, n_wm, n_mr, n_rw, n_viol, n_ready_busy;
    logic timed_out;

    cache_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_type(cpu_req_type), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
        .tag(tag), .index(index), .blk_offset(blk_offset), .req_type(req_type),
        .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
        .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
        .hit(hit), .dirty_bit(dirty_bit),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Issues one request from IDLE (called at posedge+1) and plays cache and memory until cpu_resp_valid.
    task automatic run_txn(input logic typ, input logic [31:0] addr, input logic first_hit,
                           input logic dirty, input logic replay_hit, input int wb_wait,
                           input int rf_wait, input logic intrude);
        int   probes;
        int   wcnt;
        logic prev_probe;
        logic done;
        probes = 0; wcnt = 0; prev_probe = 1'b0; done = 1'b0;
        lat = 0; n_rc = 0; n_wc = 0; n_rm = 0; n_wm = 0; n_mr = 0; n_rw = 0; n_viol = 0; n_ready_busy = 0;
        cpu_req_valid = 1'b1; cpu_req_type = typ; cpu_addr = addr;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0; cpu_req_type = 1'b0; cpu_addr = 32'd0;
        for (int c = 1; c < 60 && !done; c++) begin
            n_rc += int'(read_en_cache);
            n_wc += int'(write_en_cache);
            n_rm += int'(read_en_mem);
            n_wm += int'(write_en_mem);
            n_mr += int'(mem_req);
            n_rw += int'(mem_req && mem_rw);
            if (int'(read_en_cache) + int'(write_en_cache) + int'(read_en_mem) + int'(write_en_mem) > 1)
                n_viol++;
            if (cpu_resp_valid) begin
                lat  = c + 1;
                done = 1'b1;
            end else if (cpu_ready) begin
                n_ready_busy++;
            end
            hit        = prev_probe ? ((probes == 1) ? first_hit : replay_hit) : 1'b0;
            dirty_bit  = prev_probe ? dirty : 1'b0;
            prev_probe = read_en_cache | write_en_cache;
            if (prev_probe) probes++;
            if (mem_req) begin
                mem_ready = (wcnt == (mem_rw ? wb_wait : rf_wait));
                wcnt      = mem_ready ? 0 : wcnt + 1;
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end
            if (intrude && c == 2) begin
                cpu_req_valid = 1'b1; cpu_req_type = 1'b1; cpu_addr = 32'hFFFF_FFFC;
            end else begin
                cpu_req_valid = 1'b0; cpu_req_type = 1'b0; cpu_addr = 32'd0;
            end
            @(posedge clk); #1;
        end
        hit = 1'b0; dirty_bit = 1'b0; mem_ready = 1'b0;
        timed_out = !done;
    endtask

    initial begin
        rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_type = 1'b0; cpu_addr = 32'd0;
        hit = 1'b0; dirty_bit = 1'b0; mem_ready = 1'b0; timed_out = 1'b0;
        #12;
        chk("rst_cpu_ready", 64'(cpu_ready), 64'd1);
        chk("rst_outs", 64'({cpu_resp_valid, read_en_cache, write_en_cache, read_en_mem,
                             write_en_mem, mem_req, mem_rw, req_type}), 64'd0);
        chk("rst_counters", 64'({hit_cnt, miss_cnt, wb_cnt}), 64'd0);
        chk("rst_addr", 64'({tag, index, blk_offset}), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: read hit, address split
        run_txn(1'b0, 32'h06AF_3782, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("s1_timeout", 64'(timed_out), 64'd0);
        chk("s1_latency", 64'(lat), 64'd4);
        chk("s1_tag", 64'(tag), 64'h1ABCDE);
        chk("s1_index", 64'(index), 64'd0);
        chk("s1_offset", 64'(blk_offset), 64'd2);
        chk("s1_probe_rd", 64'(n_rc), 64'd1);
        chk("s1_mem_req", 64'(n_mr), 64'd0);
        chk("s1_counters", 64'({hit_cnt, miss_cnt, wb_cnt}), 64'({32'd1, 32'd0, 32'd0}));

        // 2 + 4: clean read miss, refill after 3 wait cycles, new request while busy ignored
        run_txn(1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 0, 3, 1'b1);
        chk("s2_timeout", 64'(timed_out), 64'd0);
        chk("s2_latency", 64'(lat), 64'd11);
        chk("s2_refill_pulses", 64'(n_rm), 64'd1);
        chk("s2_probes", 64'(n_rc), 64'd2);
        chk("s2_mem_req_cycles", 64'(n_mr), 64'd4);
        chk("s2_wb_cycles", 64'(n_wm + n_rw), 64'd0);
        chk("s2_counters", 64'({hit_cnt, miss_cnt, wb_cnt}), 64'({32'd1, 32'd1, 32'd0}));
        chk("s4_tag", 64'(tag), 64'h48);
        chk("s4_index", 64'(index), 64'hD);
        chk("s4_req_type", 64'(req_type), 64'd0);
        chk("s4_ready_busy", 64'(n_ready_busy), 64'd0);
        chk("s2_excl", 64'(n_viol), 64'd0);
        chk("s2_err", 64'(dut.err_r), 64'd0);

        // 3: write miss with dirty victim, one writeback wait cycle, zero-wait refill
        run_txn(1'b1, 32'h0000_2208, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0);
        chk("s3_timeout", 64'(timed_out), 64'd0);
        chk("s3_latency", 64'(lat), 64'd10);
        chk("s3_wr_probes", 64'(n_wc), 64'd2);
        chk("s3_rd_probes", 64'(n_rc), 64'd0);
        chk("s3_wb_en_cycles", 64'(n_wm), 64'd2);
        chk("s3_mem_rw_cycles", 64'(n_rw), 64'd2);
        chk("s3_refill_pulses", 64'(n_rm), 64'd1);
        chk("s3_mem_req_cycles", 64'(n_mr), 64'd3);
        chk("s3_req_type", 64'(req_type), 64'd1);
        chk("s3_counters", 64'({hit_cnt, miss_cnt, wb_cnt}), 64'({32'd1, 32'd2, 32'd1}));
        chk("s3_excl", 64'(n_viol), 64'd0);

        // replay that still misses: no extra counts, sticky error
        run_txn(1'b0, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("rm_timeout", 64'(timed_out), 64'd0);
        chk("rm_latency", 64'(lat), 64'd8);
        chk("rm_counters", 64'({hit_cnt, miss_cnt, wb_cnt}), 64'({32'd1, 32'd3, 32'd1}));
        chk("rm_err", 64'(dut.err_r), 64'd1);
        run_txn(1'b0, 32'h06AF_3782, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("rm_err_sticky", 64'(dut.err_r), 64'd1);
        chk("rm_hit_after", 64'(hit_cnt), 64'd2);

        // 5: reset while waiting in REFILL_REQ
        cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = 32'h0000_0100;
        @(posedge clk); #1; cpu_req_valid = 1'b0;
        @(posedge clk); #1; hit = 1'b0; dirty_bit = 1'b0;
        @(posedge clk); #1;
        chk("s5_in_refill_req", 64'({mem_req, mem_rw}), 64'b10);
        rst_n = 1'b0; #1;
        chk("s5_mem_req_drop", 64'(mem_req), 64'd0);
        chk("s5_ready", 64'(cpu_ready), 64'd1);
        chk("s5_counters", 64'({hit_cnt, miss_cnt, wb_cnt}), 64'd0);
        chk("s5_err_clear", 64'(dut.err_r), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        n_ready_busy = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_ready_busy += int'(cpu_resp_valid) + int'(!cpu_ready);
        end
        chk("s5_idle_after", 64'(n_ready_busy), 64'd0);

        // write hit, then 6: saturation of hit_cnt
        run_txn(1'b1, 32'h0000_0204, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("wh_latency", 64'(lat), 64'd4);
        chk("wh_wr_probe", 64'(n_wc), 64'd1);
        chk("wh_hit_cnt", 64'(hit_cnt), 64'd1);
        force dut.hit_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt_r;
        #1;
        chk("s6_preset", 64'(hit_cnt), 64'hFFFF_FFFF);
        run_txn(1'b0, 32'h0000_0208, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("s6_timeout", 64'(timed_out), 64'd0);
        chk("s6_saturated", 64'(hit_cnt), 64'hFFFF_FFFF);
        chk("s6_miss_cnt", 64'(miss_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
